// File: rtl/ysyx_24090018_fetch_ctrl_if.sv
// ysyx_24090018_fetch_ctrl_if: instruction-memory request/response and decode handshake bundle
interface ysyx_24090018_fetch_ctrl_if #(parameter int ADDR_WIDTH = 32);
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [ADDR_WIDTH-1:0] imem_req_addr_o;
  logic                  imem_rsp_valid_i;
  logic [31:0]           imem_rsp_data_i;
  logic                  imem_rsp_err_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [31:0]           inst_o;
  logic [ADDR_WIDTH-1:0] inst_pc_o;
  logic                  jump_flag_i;
  logic [31:0]           jump_addr_i;
  modport master (
    output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
           inst_ready_i, jump_flag_i, jump_addr_i
  );
  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
           inst_ready_i, jump_flag_i, jump_addr_i
  );
endinterface

// File: rtl/ysyx_24090018_fetch_ctrl.sv
// ysyx_24090018_fetch_ctrl: single-outstanding instruction fetch sequencer with flush redirect and stale-response drop
module ysyx_24090018_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24090018_fetch_ctrl_if.master  bus,
  input  logic                        flush_i,
  input  logic [31:0]                 flush_addr_i,
  output logic [ADDR_WIDTH-1:0]       pc_o,
  output logic                        halted_o,
  output logic [31:0]                 fetch_cnt_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_d, inst_pc_d, flush_pc;
  logic [31:0]           inst_d, cnt_d;
  logic                  drop_q, drop_d;
  assign flush_pc             = ADDR_WIDTH'(flush_addr_i);
  assign bus.imem_req_valid_o = state_q == REQ;
  assign bus.imem_req_addr_o  = pc_o;
  assign bus.inst_valid_o     = state_q == HOLD;
  assign halted_o             = state_q == HALT;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_o;
    drop_d    = drop_q;
    inst_d    = bus.inst_o;
    inst_pc_d = bus.inst_pc_o;
    cnt_d     = fetch_cnt_o;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d    = flush_i ? flush_pc : pc_o;
      end
      REQ: begin
        pc_d = flush_i ? flush_pc : pc_o;
        if (bus.imem_req_ready_i) begin
          state_d = WAIT;
          drop_d  = flush_i;
        end
      end
      WAIT: begin
        if (flush_i) begin
          pc_d   = flush_pc;
          drop_d = 1'b1;
        end
        // a flush arriving with the response kills it just like an earlier flush
        if (bus.imem_rsp_valid_i) begin
          if (drop_q || flush_i) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else if (bus.imem_rsp_err_i) begin
            state_d = HALT;
          end else begin
            state_d   = HOLD;
            inst_d    = bus.imem_rsp_data_i;
            inst_pc_d = pc_o;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = REQ;
          pc_d    = flush_pc;
        end else if (bus.inst_ready_i) begin
          state_d = REQ;
          pc_d    = bus.jump_flag_i ? ADDR_WIDTH'(bus.jump_addr_i) : pc_o + ADDR_WIDTH'(4);
          cnt_d   = fetch_cnt_o + 32'd1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_o          <= RESET_PC;
      drop_q        <= 1'b0;
      bus.inst_o    <= '0;
      bus.inst_pc_o <= '0;
      fetch_cnt_o   <= '0;
    end else begin
      state_q       <= state_d;
      pc_o          <= pc_d;
      drop_q        <= drop_d;
      bus.inst_o    <= inst_d;
      bus.inst_pc_o <= inst_pc_d;
      fetch_cnt_o   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_24090018_fetch_ctrl.sv
// tb_ysyx_24090018_fetch_ctrl: vector table plus hand sequences, scoreboard of accepted fetches vs decoded instructions
module tb_ysyx_24090018_fetch_ctrl;
  typedef struct {
    logic [31:0] addr;
    int          wait_c;
    int          req_stall;
    int          lat;
    int          dec_stall;
    logic        jump;
    logic [31:0] jaddr;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic [31:0] pc_o, fetch_cnt_o;
  logic        halted_o;
  int          pass_cnt = 0, tot_cnt = 0, cyc = 0;
  logic [31:0] exp_cnt = '0;
  logic [63:0] sb[$];
  vec_t        vecs[6];
  ysyx_24090018_fetch_ctrl_if #(.ADDR_WIDTH(32)) bus();
  ysyx_24090018_fetch_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .pc_o(pc_o), .halted_o(halted_o), .fetch_cnt_o(fetch_cnt_o)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic accept();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
  endtask
  task automatic respond(input logic [31:0] d, input logic err);
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = d;
    bus.imem_rsp_err_i   = err;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
  endtask
  task automatic fetch_one(input vec_t v);
    int n;
    logic [63:0] e;
    n = 0;
    while (!bus.imem_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("req_wait", 64'(n), 64'(v.wait_c));
    chk("req_addr", bus.imem_req_addr_o, v.addr);
    for (int i = 0; i < v.req_stall; i++) begin
      tick();
      chk("req_hold", {bus.imem_req_valid_o, bus.imem_req_addr_o}, {1'b1, v.addr});
    end
    sb.push_back({v.addr, mem(v.addr)});
    accept();
    chk("req_low", bus.imem_req_valid_o, 0);
    for (int i = 0; i < v.lat; i++) begin
      chk("wait_no_inst", bus.inst_valid_o, 0);
      tick();
    end
    respond(mem(v.addr), 1'b0);
    chk("inst_valid", bus.inst_valid_o, 1);
    e = sb.size() > 0 ? sb.pop_front() : 64'hx;
    chk("inst_pc", bus.inst_pc_o, e[63:32]);
    chk("inst", bus.inst_o, e[31:0]);
    for (int i = 0; i < v.dec_stall; i++) begin
      tick();
      chk("inst_hold", {bus.inst_valid_o, bus.inst_pc_o, bus.inst_o}, {1'b1, e});
      chk("cnt_hold", fetch_cnt_o, exp_cnt);
    end
    bus.jump_flag_i  = v.jump;
    bus.jump_addr_i  = v.jaddr;
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    bus.jump_flag_i  = 1'b0;
    exp_cnt++;
    chk("cnt", fetch_cnt_o, exp_cnt);
    chk("inst_done", bus.inst_valid_o, 0);
  endtask
  initial begin
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.inst_ready_i     = 1'b0;
    bus.jump_flag_i      = 1'b0;
    bus.jump_addr_i      = '0;
    vecs[0] = '{32'h8000_0000, 1, 0, 0, 0, 1'b0, 32'h0};
    vecs[1] = '{32'h8000_0004, 0, 0, 0, 0, 1'b1, 32'h8000_0100};
    vecs[2] = '{32'h8000_0100, 0, 0, 0, 0, 1'b0, 32'hFFFF_FFF0};
    vecs[3] = '{32'h8000_0104, 0, 4, 0, 5, 1'b0, 32'h0};
    vecs[4] = '{32'h8000_0108, 0, 0, 2, 0, 1'b0, 32'h0};
    vecs[5] = '{32'h8000_010C, 0, 1, 1, 1, 1'b0, 32'h0};
    tick();
    tick();
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_flags", {bus.imem_req_valid_o, bus.inst_valid_o, halted_o}, 0);
    chk("rst_inst", {bus.inst_o, bus.inst_pc_o}, 0);
    chk("rst_cnt", fetch_cnt_o, 0);
    rst = 1'b1;
    chk("idle_no_req", bus.imem_req_valid_o, 0);
    foreach (vecs[i]) fetch_one(vecs[i]);
    // flush while waiting, response two cycles later
    chk("pre_flush_addr", bus.imem_req_addr_o, 32'h8000_0110);
    accept();
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0200;
    tick();
    flush_i = 1'b0;
    chk("wflush_pc", {bus.imem_req_valid_o, pc_o}, {1'b0, 32'h8000_0200});
    tick();
    chk("wflush_no_inst", bus.inst_valid_o, 0);
    respond(32'hDEAD_BEEF, 1'b0);
    chk("wflush_drop", {bus.inst_valid_o, bus.imem_req_valid_o}, 2'b01);
    chk("wflush_addr", bus.imem_req_addr_o, 32'h8000_0200);
    fetch_one('{32'h8000_0200, 0, 0, 0, 0, 1'b0, 32'h0});
    // flush and response in the same cycle
    accept();
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0300;
    respond(32'hBAD0_BAD0, 1'b0);
    flush_i = 1'b0;
    chk("sflush_drop", {bus.inst_valid_o, bus.imem_req_valid_o}, 2'b01);
    chk("sflush_addr", bus.imem_req_addr_o, 32'h8000_0300);
    // flush while request is stalled
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0400;
    tick();
    flush_i = 1'b0;
    chk("rflush_addr", {bus.imem_req_valid_o, bus.imem_req_addr_o}, {1'b1, 32'h8000_0400});
    // flush beats the decode handshake
    accept();
    respond(mem(32'h8000_0400), 1'b0);
    chk("hflush_hold", bus.inst_valid_o, 1);
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0500;
    bus.inst_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    bus.inst_ready_i = 1'b0;
    chk("hflush_state", {bus.inst_valid_o, bus.imem_req_valid_o}, 2'b01);
    chk("hflush_addr", bus.imem_req_addr_o, 32'h8000_0500);
    chk("hflush_cnt", fetch_cnt_o, exp_cnt);
    // wrap of the sequential PC
    flush_i = 1'b1;
    flush_addr_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    fetch_one('{32'hFFFF_FFFC, 0, 0, 0, 0, 1'b0, 32'h0});
    chk("wrap_addr", bus.imem_req_addr_o, 32'h0000_0000);
    // access fault halts fetch permanently
    accept();
    respond(32'h0, 1'b1);
    chk("halted", {halted_o, bus.imem_req_valid_o, bus.inst_valid_o}, 3'b100);
    flush_i = 1'b1;
    flush_addr_i = 32'h8000_0600;
    tick();
    flush_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stuck", {halted_o, bus.imem_req_valid_o, pc_o}, {2'b10, 32'h0});
    end
    bus.imem_req_ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_halt", {halted_o, pc_o}, {1'b0, 32'h8000_0000});
    chk("arst_cnt", {fetch_cnt_o, bus.inst_o}, 0);
    tick();
    rst = 1'b1;
    exp_cnt = '0;
    fetch_one('{32'h8000_0000, 1, 0, 0, 0, 1'b0, 32'h0});
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/ysyx_24090018_fetch_ctrl.md
# ysyx_24090018_fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives it through a request/response handshake with instruction memory. It issues one fetch at a time, buffers the returned instruction, hands it to the decode/execute stage over a valid/ready handshake, and then advances the PC sequentially or to a jump target. It also handles asynchronous flush redirects and discards stale responses. It sits between the instruction-memory port and the IDU/EXU front end.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  ADDR_WIDTH  fetch address (= pc_o)
- imem_rsp_valid_i  in  1  response valid, single-cycle pulse
- imem_rsp_data_i  in  32  fetched instruction
- imem_rsp_err_i  in  1  access fault, qualified by imem_rsp_valid_i
- inst_valid_o  out  1  buffered instruction valid to decode
- inst_ready_i  in  1  decode accepts instruction
- inst_o  out  32  buffered instruction
- inst_pc_o  out  ADDR_WIDTH  PC of inst_o
- jump_flag_i  in  1  taken branch/jump for the instruction being accepted
- jump_addr_i  in  32  jump target
- flush_i  in  1  redirect request (exception/trap return); any state
- flush_addr_i  in  32  flush target
- pc_o  out  ADDR_WIDTH  current fetch PC
- halted_o  out  1  sticky fetch-fault indicator
- fetch_cnt_o  out  32  count of instructions handed to decode

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. Reset → IDLE. Outputs are decoded from state: req_valid = REQ, inst_valid = HOLD, halted = HALT.
- IDLE: always moves to REQ after one cycle. A flush in IDLE loads pc ← flush_addr_i.
- REQ: imem_req_addr_o = pc_o. If imem_req_ready_i is high → WAIT. The address stays stable while valid and not ready, except on flush.
- WAIT: waits for imem_rsp_valid_i.
  - If the drop flag is set → REQ. The response is discarded and the drop flag is cleared.
  - Else if imem_rsp_err_i → HALT.
  - Else inst_o ← data and inst_pc_o ← pc_o → HOLD.
- HOLD: on inst_ready_i, pc ← jump_flag_i ? jump_addr_i : pc_o + 4 (mod 2^ADDR_WIDTH wrap), fetch_cnt_o += 1 (wraps), → REQ.
- HALT: terminal state. No requests are issued, and flush and jump are ignored. Only reset exits.
- Flush handling (flush has priority over jump and over inst_ready_i):
  - IDLE/HOLD: pc ← flush_addr_i → REQ. The HOLD instruction is discarded and fetch_cnt_o is not incremented.
  - REQ without ready: pc ← flush_addr_i, stay in REQ. The new address appears the next cycle.
  - REQ with ready: the old-address request is issued. pc ← flush_addr_i, drop ← 1 → WAIT.
  - WAIT: pc ← flush_addr_i, drop ← 1. If rsp_valid arrives in the same cycle, that response is dropped and the FSM → REQ.
- jump_flag_i and jump_addr_i are sampled only at the HOLD handshake cycle.
- The drop flag is internal, 1 bit, and cleared on reset.

## Timing
- Reset values: pc_o = RESET_PC, imem_req_valid_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, halted_o = 0, fetch_cnt_o = 0, state = IDLE, drop = 0.
- The first request is asserted in the 2nd cycle after reset deassertion.
- Response timing: a response is valid no earlier than the cycle after request acceptance. rsp_valid outside WAIT is ignored.
- Minimum cost is 3 cycles per instruction (REQ → WAIT → HOLD) with zero-wait memory and decode.
- Instruction registration:
  - inst_o and inst_pc_o are registered.
  - inst_valid_o rises the cycle after the response.
  - inst_o and inst_pc_o are held stable until the handshake or a flush.
- pc_o updates on the edge that ends the HOLD handshake. The next imem_req_addr_o shows the new PC in the following cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). An outstanding memory response after reset lands in IDLE/REQ and is ignored.

## Test plan
- **Sequential fetch:** reset, then memory with ready=1 and a 1-cycle response, decode with ready=1, 3 instructions. Expect request addresses 0x80000000, 0x80000004, 0x80000008; each inst_pc_o matches; fetch_cnt_o = 3; 3 cycles per instruction.
- **Jump:** at the HOLD handshake of inst @0x80000004, assert jump_flag_i=1 with jump_addr_i=0x80000100. Expect the next request address = 0x80000100.
- **Backpressure:** hold imem_req_ready_i=0 for 4 cycles, then inst_ready_i=0 for 5 cycles. Expect the request address stable, inst_o and inst_pc_o stable, and fetch_cnt_o unchanged until the handshake.
- **Flush in WAIT:** assert flush_i with flush_addr_i=0x80000200 while the response is outstanding, with the response returning 2 cycles later. Expect the response dropped, inst_valid_o never asserted for it, and the next request address 0x80000200. Repeat with flush and response in the same cycle.
- **Fault:** a response with imem_rsp_err_i=1. Expect halted_o=1 the next cycle, no further requests, and flush ignored; async reset clears halted_o and pc_o returns to 0x80000000.
- **Wrap:** pc_o=0xFFFFFFFC via flush. Expect the sequential next address 0x00000000; fetch_cnt_o preset near 0xFFFFFFFF wraps to 0.
